// File: rtl/uart_autobaud_pkg.sv
// Shared definitions for the UART auto-baud controller.
//   state_e     : measurement FSM states
//   SYNC_EDGES  : edges following the start edge of a 0x55 sync character (ends on bit7 fall)
//   ROUND_SHIFT : divide-by-64 turning an 8-bit measurement into a per-1/8-bit prescale
//   ROUND_ADD   : half of 2**ROUND_SHIFT, for round-to-nearest
package uart_autobaud_pkg;

  typedef enum logic [2:0] {
    StIdleWait,
    StArmed,
    StMeasure,
    StCalc,
    StWaitStop,
    StLocked
  } state_e;

  localparam int unsigned SYNC_EDGES  = 8;
  localparam int unsigned ROUND_SHIFT = 6;
  localparam int unsigned ROUND_ADD   = 32;

endpackage

// File: rtl/uart_autobaud_if.sv
// Control/status bundle between system logic and the auto-baud controller.
//   cfg_auto     : 1 = auto-baud, 0 = manual prescale
//   cfg_prescale : manual prescale value
//   relock       : single-cycle pulse, discard the lock and re-measure
//   prescale     : prescale value handed to uart_rx
//   locked       : prescale is valid
//   busy         : measurement in progress
//   error        : single-cycle pulse on a failed measurement
// master = system/controller side, slave = auto-baud block.
interface uart_autobaud_if;
  logic        cfg_auto;
  logic [15:0] cfg_prescale;
  logic        relock;
  logic [15:0] prescale;
  logic        locked;
  logic        busy;
  logic        error;

  modport master (
    output cfg_auto, cfg_prescale, relock,
    input  prescale, locked, busy, error
  );

  modport slave (
    input  cfg_auto, cfg_prescale, relock,
    output prescale, locked, busy, error
  );
endinterface

// File: rtl/uart_edge_sync.sv
// Two-flop synchroniser for an asynchronous serial line plus single-cycle edge strobes.
//   clk    : system clock
//   rst    : synchronous active-high reset, all flops load ResetVal (idle line level)
//   din_i  : asynchronous input
//   dout_o : synchronised level
//   rise_o : synchronised level went 0 -> 1 this cycle
//   fall_o : synchronised level went 1 -> 0 this cycle
module uart_edge_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
      prev_q <= ResetVal;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign dout_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/uart_autobaud.sv
// Auto-baud controller: measures a 0x55 sync character on rxd and derives the uart_rx prescale
// (bit period = 8 * prescale clk cycles), with a manual override.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   rxd  : raw asynchronous UART line
//   ctrl : control/status bundle (cfg_auto, cfg_prescale, relock -> prescale, locked, busy, error)
module uart_autobaud
  import uart_autobaud_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH     = 22,
  parameter int unsigned IDLE_CYCLES     = 1024,
  parameter int unsigned MIN_HALF_CYCLES = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 2**22 - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rxd,
  uart_autobaud_if.slave  ctrl
);

  // total_cnt spans up to SYNC_EDGES intervals, each below the timeout, hence 3 extra bits.
  localparam int unsigned TotalWidth = COUNT_WIDTH + 3;
  localparam int unsigned IntWidth   = COUNT_WIDTH + 1;
  localparam int unsigned CalcWidth  = TotalWidth + 2;

  localparam logic [COUNT_WIDTH-1:0] IdleLast   = COUNT_WIDTH'(IDLE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] TimeoutCnt = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [IntWidth-1:0]    MinInt     = IntWidth'(MIN_HALF_CYCLES);
  localparam logic [3:0]             LastEdge   = 4'(SYNC_EDGES - 1);

  logic rxd_s, rxd_rise, rxd_fall, rxd_edge;

  uart_edge_sync #(
    .ResetVal (1'b1)
  ) u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .din_i  (rxd),
    .dout_o (rxd_s),
    .rise_o (rxd_rise),
    .fall_o (rxd_fall)
  );

  assign rxd_edge = rxd_rise | rxd_fall;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
  logic [COUNT_WIDTH-1:0] int_cnt_q, int_cnt_d;
  logic [TotalWidth-1:0]  total_cnt_q, total_cnt_d;
  logic [IntWidth-1:0]    ref_int_q, ref_int_d;
  logic [3:0]             edge_cnt_q, edge_cnt_d;
  logic [TotalWidth:0]    n_q, n_d;
  logic [15:0]            prescale_q, prescale_d;
  logic                   locked_q, locked_d;
  logic                   error_q, error_d;

  // An edge seen with int_cnt == k closes an interval of k+1 cycles.
  logic [IntWidth-1:0] interval, deviation;
  logic                tol_fail;

  always_comb begin
    interval  = {1'b0, int_cnt_q} + IntWidth'(1);
    deviation = (interval >= ref_int_q) ? (interval - ref_int_q) : (ref_int_q - interval);
    tol_fail  = deviation > (ref_int_q >> 2);
  end

  // Rounded divide of N by 64, saturated to 16 bits.
  logic [CalcWidth-1:0] calc_sum, calc_p;
  logic [15:0]          calc_sat;

  always_comb begin
    calc_sum = {1'b0, n_q} + CalcWidth'(ROUND_ADD);
    calc_p   = calc_sum >> ROUND_SHIFT;
    calc_sat = (calc_p > CalcWidth'(16'hFFFF)) ? 16'hFFFF : calc_p[15:0];
  end

  logic fail;

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    int_cnt_d   = int_cnt_q;
    total_cnt_d = total_cnt_q;
    ref_int_d   = ref_int_q;
    edge_cnt_d  = edge_cnt_q;
    n_d         = n_q;
    prescale_d  = prescale_q;
    locked_d    = locked_q;
    error_d     = 1'b0;
    fail        = 1'b0;

    unique case (state_q)
      StIdleWait: begin
        if (!rxd_s) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IdleLast) begin
          idle_cnt_d = '0;
          state_d    = StArmed;
        end else begin
          idle_cnt_d = idle_cnt_q + COUNT_WIDTH'(1);
        end
      end

      StArmed: begin
        if (rxd_fall) begin
          total_cnt_d = '0;
          int_cnt_d   = '0;
          edge_cnt_d  = '0;
          state_d     = StMeasure;
        end
      end

      StMeasure: begin
        total_cnt_d = total_cnt_q + TotalWidth'(1);
        int_cnt_d   = int_cnt_q + COUNT_WIDTH'(1);
        // Timeout is checked first so an edge landing on the timeout cycle still fails.
        if (int_cnt_q == TimeoutCnt) begin
          fail = 1'b1;
        end else if (rxd_edge) begin
          int_cnt_d  = '0;
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (interval < MinInt) begin
            fail = 1'b1;
          end else if (edge_cnt_q == 4'd0) begin
            ref_int_d = interval;
          end else if (tol_fail) begin
            fail = 1'b1;
          end
          if (!fail && edge_cnt_q == LastEdge) begin
            n_d     = {1'b0, total_cnt_q} + (TotalWidth + 1)'(1);
            state_d = StCalc;
          end
        end
      end

      StCalc: begin
        if (calc_sat == 16'd0) begin
          fail = 1'b1;
        end else begin
          prescale_d = calc_sat;
          state_d    = StWaitStop;
        end
      end

      StWaitStop: begin
        if (rxd_s) begin
          locked_d = 1'b1;
          state_d  = StLocked;
        end
      end

      StLocked: ;

      default: state_d = StIdleWait;
    endcase

    if (fail) begin
      error_d     = 1'b1;
      locked_d    = 1'b0;
      state_d     = StIdleWait;
      idle_cnt_d  = '0;
      int_cnt_d   = '0;
      total_cnt_d = '0;
      edge_cnt_d  = '0;
    end

    // Relock and manual mode win over everything, including a CALC result in the same cycle.
    if (ctrl.relock || !ctrl.cfg_auto) begin
      error_d     = 1'b0;
      locked_d    = 1'b0;
      prescale_d  = prescale_q;
      state_d     = StIdleWait;
      idle_cnt_d  = '0;
      int_cnt_d   = '0;
      total_cnt_d = '0;
      edge_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdleWait;
      idle_cnt_q  <= '0;
      int_cnt_q   <= '0;
      total_cnt_q <= '0;
      ref_int_q   <= '0;
      edge_cnt_q  <= '0;
      n_q         <= '0;
      prescale_q  <= '0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      int_cnt_q   <= int_cnt_d;
      total_cnt_q <= total_cnt_d;
      ref_int_q   <= ref_int_d;
      edge_cnt_q  <= edge_cnt_d;
      n_q         <= n_d;
      prescale_q  <= prescale_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
    end
  end

  assign ctrl.prescale = ctrl.cfg_auto ? prescale_q : ctrl.cfg_prescale;
  assign ctrl.locked   = ctrl.cfg_auto ? locked_q : 1'b1;
  assign ctrl.busy     = ctrl.cfg_auto & ((state_q == StMeasure) | (state_q == StWaitStop));
  assign ctrl.error    = error_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Scoreboard bench for uart_autobaud. Stimulus is described as a list of line segments
// (level, length); a segment-level model predicts lock/prescale or error, pushes it into a queue,
// and a negedge monitor pops and compares whenever the DUT pulses error or raises locked.
module tb_uart_autobaud;

  localparam int unsigned TbIdle    = 1024;
  localparam int unsigned TbMin     = 8;
  localparam int unsigned TbTimeout = 4000;

  typedef struct {
    bit is_err;
    int p;
  } exp_t;

  logic clk, rst, rxd;
  uart_autobaud_if ctrl_if ();

  uart_autobaud #(
    .COUNT_WIDTH     (22),
    .IDLE_CYCLES     (TbIdle),
    .MIN_HALF_CYCLES (TbMin),
    .TIMEOUT_CYCLES  (TbTimeout)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rxd  (rxd),
    .ctrl (ctrl_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  bit   seg_lvl[$];
  int   seg_len[$];
  int   last_p = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input bit lvl, input int n);
    rxd = lvl;
    repeat (n) step();
  endtask

  task automatic clear_segs();
    seg_lvl.delete();
    seg_len.delete();
  endtask

  task automatic add_seg(input bit lvl, input int n);
    int idx;
    idx = seg_len.size() - 1;
    if (idx >= 0 && seg_lvl[idx] == lvl) seg_len[idx] = seg_len[idx] + n;
    else begin
      seg_lvl.push_back(lvl);
      seg_len.push_back(n);
    end
  endtask

  task automatic add_byte(input logic [7:0] b, input int t);
    add_seg(1'b0, t);
    for (int i = 0; i < 8; i++) add_seg(b[i], t);
    add_seg(1'b1, t);
  endtask

  // Reference: the first 8 segment lengths after the start edge are the measured intervals.
  task automatic predict(output exp_t e);
    int ref_len, n, len, dev;
    e.is_err = 1'b0;
    e.p      = last_p;
    n        = 0;
    ref_len  = 0;
    for (int k = 0; k < 8; k++) begin
      if (k >= seg_len.size()) begin
        e.is_err = 1'b1;
        return;
      end
      len = seg_len[k];
      if (len > int'(TbTimeout) || len < int'(TbMin)) begin
        e.is_err = 1'b1;
        return;
      end
      if (k == 0) ref_len = len;
      else begin
        dev = (len > ref_len) ? len - ref_len : ref_len - len;
        if (dev > ref_len / 4) begin
          e.is_err = 1'b1;
          return;
        end
      end
      n += len;
    end
    e.p = (n + 32) / 64;
    if (e.p > 65535) e.p = 65535;
    if (e.p == 0) begin
      e.is_err = 1'b1;
      e.p      = last_p;
    end else begin
      last_p = e.p;
    end
  endtask

  task automatic play_segs();
    for (int i = 0; i < seg_len.size(); i++) hold(seg_lvl[i], seg_len[i]);
  endtask

  // Idle long enough to arm, then the predicted frame, then a short high tail.
  task automatic run_frame();
    exp_t e;
    hold(1'b1, TbIdle + 80);
    predict(e);
    exp_q.push_back(e);
    play_segs();
    hold(1'b1, 20);
  endtask

  task automatic sync_byte(input logic [7:0] b, input int t);
    clear_segs();
    add_byte(b, t);
    run_frame();
  endtask

  task automatic pulse_relock();
    ctrl_if.relock = 1'b1;
    step();
    ctrl_if.relock = 1'b0;
  endtask

  // Monitor / scoreboard.
  bit   lk_prev, cfg_prev, err_prev;
  exp_t got;

  initial begin
    lk_prev  = 1'b0;
    cfg_prev = 1'b0;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lk_prev  = 1'b0;
        cfg_prev = 1'b0;
        err_prev = 1'b0;
      end else begin
        if (ctrl_if.error) begin
          check("error_pulse_width", longint'(err_prev), 0);
          if (exp_q.size() == 0) check("unexpected_error", longint'(ctrl_if.error), 0);
          else begin
            got = exp_q.pop_front();
            check("event_is_error", 1, longint'(got.is_err));
            check("prescale_after_error", longint'(ctrl_if.prescale), longint'(got.p));
          end
        end
        if (ctrl_if.locked && !lk_prev && ctrl_if.cfg_auto && cfg_prev) begin
          if (exp_q.size() == 0) check("unexpected_lock", longint'(ctrl_if.locked), 0);
          else begin
            got = exp_q.pop_front();
            check("event_is_lock", 0, longint'(got.is_err));
            check("prescale_at_lock", longint'(ctrl_if.prescale), longint'(got.p));
          end
        end
        lk_prev  = ctrl_if.locked;
        cfg_prev = ctrl_if.cfg_auto;
        err_prev = ctrl_if.error;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int t, k, d;
    logic [7:0] g;
    rst                  = 1'b1;
    rxd                  = 1'b1;
    ctrl_if.cfg_auto     = 1'b1;
    ctrl_if.cfg_prescale = 16'h0;
    ctrl_if.relock       = 1'b0;
    repeat (3) step();
    check("reset_prescale", longint'(ctrl_if.prescale), 0);
    check("reset_locked", longint'(ctrl_if.locked), 0);
    check("reset_busy", longint'(ctrl_if.busy), 0);
    check("reset_error", longint'(ctrl_if.error), 0);
    rst = 1'b0;
    step();

    // Manual override.
    ctrl_if.cfg_auto     = 1'b0;
    ctrl_if.cfg_prescale = 16'h1234;
    #1;
    check("manual_prescale", longint'(ctrl_if.prescale), 'h1234);
    check("manual_locked", longint'(ctrl_if.locked), 1);
    step();
    step();
    ctrl_if.cfg_auto = 1'b1;
    #1;
    check("auto_reenable_locked", longint'(ctrl_if.locked), 0);
    step();

    sync_byte(8'h55, 64);
    check("locked_after_64", longint'(ctrl_if.locked), 1);

    pulse_relock();
    sync_byte(8'h55, 868);
    check("locked_after_868", longint'(ctrl_if.locked), 1);

    // Ordinary traffic while locked must not disturb the lock.
    clear_segs();
    add_byte(8'hA3, 868);
    play_segs();
    hold(1'b1, 50);
    check("locked_through_a3", longint'(ctrl_if.locked), 1);
    check("prescale_through_a3", longint'(ctrl_if.prescale), 109);

    // 4-cycle low glitch inside bit2.
    pulse_relock();
    g = 8'h55;
    clear_segs();
    add_seg(1'b0, 64);
    add_seg(1'b1, 64);
    add_seg(1'b0, 64);
    add_seg(1'b1, 30);
    add_seg(1'b0, 4);
    add_seg(1'b1, 30);
    for (int i = 3; i < 8; i++) add_seg(g[i], 64);
    add_seg(1'b1, 64);
    run_frame();
    check("glitch_locked", longint'(ctrl_if.locked), 0);
    check("glitch_prescale_kept", longint'(ctrl_if.prescale), 109);

    sync_byte(8'h55, 64);
    check("retry_locked", longint'(ctrl_if.locked), 1);

    // Relock together with a line edge.
    rxd            = 1'b0;
    ctrl_if.relock = 1'b1;
    step();
    ctrl_if.relock = 1'b0;
    check("relock_locked", longint'(ctrl_if.locked), 0);
    check("relock_prescale_kept", longint'(ctrl_if.prescale), 8);
    hold(1'b0, 63);

    sync_byte(8'h55, 128);
    check("locked_after_128", longint'(ctrl_if.locked), 1);

    pulse_relock();
    clear_segs();
    add_seg(1'b0, TbTimeout + 50);
    run_frame();

    sync_byte(8'h0F, 64);

    // Tolerance boundary: +16 on a 64-cycle reference passes, +17 fails.
    clear_segs();
    add_byte(8'h55, 64);
    seg_len[3] = seg_len[3] + 16;
    run_frame();
    pulse_relock();
    clear_segs();
    add_byte(8'h55, 64);
    seg_len[3] = seg_len[3] + 17;
    run_frame();

    // Minimum interval boundary.
    sync_byte(8'h55, 8);
    pulse_relock();
    sync_byte(8'h55, 7);

    for (int r = 0; r < 6; r++) begin
      pulse_relock();
      t = int'($urandom_range(16, 120));
      clear_segs();
      add_byte(8'h55, t);
      if ($urandom_range(0, 1) == 1) begin
        k          = int'($urandom_range(0, 7));
        d          = int'($urandom_range(0, t)) - t / 2;
        seg_len[k] = seg_len[k] + d;
      end
      run_frame();
    end

    // Reset in the middle of a measurement.
    pulse_relock();
    hold(1'b1, TbIdle + 80);
    clear_segs();
    add_byte(8'h55, 64);
    for (int i = 0; i < 3; i++) hold(seg_lvl[i], seg_len[i]);
    check("busy_in_measure", longint'(ctrl_if.busy), 1);
    rst = 1'b1;
    step();
    check("rst_prescale", longint'(ctrl_if.prescale), 0);
    check("rst_locked", longint'(ctrl_if.locked), 0);
    check("rst_busy", longint'(ctrl_if.busy), 0);
    check("rst_error", longint'(ctrl_if.error), 0);
    rst    = 1'b0;
    last_p = 0;
    for (int i = 3; i < seg_len.size(); i++) hold(seg_lvl[i], seg_len[i]);
    hold(1'b1, 40);

    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) step();
    check("queue_drained", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
